// File: rtl/regfile_dump.sv
// Streams a contiguous range of register-file words out over a valid/ready port.
// Read-only: it drives the read-port address and captures the returned data.
module regfile_dump #(
    parameter int NUM_REGS   = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  CLK,
    input  logic                  nReset,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [ADDR_WIDTH-1:0] FirstAddress,
    input  logic [ADDR_WIDTH-1:0] LastAddress,
    output logic [ADDR_WIDTH-1:0] ReadAddress,
    input  logic [DATA_WIDTH-1:0] ReadData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic [ADDR_WIDTH-1:0] OutAddress,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    // One extra bit so NUM_REGS == 2**ADDR_WIDTH is still representable.
    localparam logic [ADDR_WIDTH:0]   REG_LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic                  range_ok;
    logic                  start_ok;
    logic                  start_bad;
    logic                  handshake;
    logic                  at_last;

    function automatic logic range_valid(input logic [ADDR_WIDTH-1:0] first,
                                         input logic [ADDR_WIDTH-1:0] last);
        return (first <= last) && ({1'b0, last} < REG_LIMIT);
    endfunction

    assign range_ok  = range_valid(FirstAddress, LastAddress);
    assign start_ok  = (state == IDLE) && Start && range_ok;
    assign start_bad = (state == IDLE) && Start && !range_ok;
    assign handshake = OutValid && OutReady;
    assign at_last   = (ReadAddress == last_addr);

    always_ff @(posedge CLK) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Abort wins over a same-cycle handshake; the beat is still consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_ok) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                state_nxt = Abort ? IDLE : HOLD;
            end
            HOLD: begin
                if (Abort) begin
                    state_nxt = IDLE;
                end else if (handshake) begin
                    state_nxt = at_last ? DONE : READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        OutValid = (state == HOLD);
        Busy     = (state != IDLE);
        Done     = (state == DONE);
    end

    always_ff @(posedge CLK) begin
        if (!nReset) begin
            ReadAddress <= '0;
            last_addr   <= '0;
            OutData     <= '0;
            OutAddress  <= '0;
            Error       <= 1'b0;
        end else begin
            Error <= start_bad;
            if (start_ok) begin
                ReadAddress <= FirstAddress;
                last_addr   <= LastAddress;
            end
            if ((state == READ) && !Abort) begin
                OutData    <= ReadData;
                OutAddress <= ReadAddress;
            end
            // Never step past the latched end of the range.
            if ((state == HOLD) && handshake && !Abort && !at_last) begin
                ReadAddress <= ReadAddress + ADDR_ONE;
            end
        end
    end

endmodule
